fighter_controller: RTL and testbench

FIGHTER_CONTROLLER -- requirements
Module: fighter_controller

---
 rtl/fighter_controller.sv | 171 +++++++++++++++++
 tb/tb_fighter_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_controller.sv
// Fighter character controller: movement, attack and stun FSM updated once per frame.
// Ports: clk, reset (sync, active-high), hcount/vcount (VGA timing), btn_left/btn_right/btn_attack,
//        hit (opponent strike pulse); sprite_position, sprite_select, attack_active, state (registered).
module fighter_controller #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SPRITE_WIDTH  = 8,
    parameter int START_X       = 100,
    parameter int TICK_LINE     = 480,
    parameter int WALK_STEP     = 2,
    parameter int KNOCKBACK     = 4,
    parameter int ANIM_PERIOD   = 8,
    parameter int ATTACK_FRAMES = 12,
    parameter int STUN_FRAMES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       hit,
    output logic [9:0] sprite_position,
    output logic [2:0] sprite_select,
    output logic       attack_active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2,
        ST_STUN   = 2'd3
    } state_t;

    localparam int TMAX = (ATTACK_FRAMES > STUN_FRAMES) ? ATTACK_FRAMES : STUN_FRAMES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int CW   = (ANIM_PERIOD > 2) ? $clog2(ANIM_PERIOD) : 1;

    localparam logic signed [10:0] WSTEP = 11'(WALK_STEP);
    localparam logic signed [10:0] KBACK = 11'(KNOCKBACK);
    localparam logic signed [10:0] MAX_X = 11'(SCREEN_WIDTH - SPRITE_WIDTH);
    localparam logic [TW-1:0] ATK_LOAD  = TW'(ATTACK_FRAMES - 1);
    localparam logic [TW-1:0] STUN_LOAD = TW'(STUN_FRAMES - 1);
    localparam logic [TW-1:0] ATK_HALF  = TW'(ATTACK_FRAMES / 2);
    localparam logic [CW-1:0] ANIM_LAST = CW'(ANIM_PERIOD - 1);

    state_t        cur, nxt;
    logic [TW-1:0] timer, timer_n;
    logic [CW-1:0] anim_cnt, anim_cnt_n;
    logic          anim_frame, anim_frame_n;
    logic [9:0]    pos_n;
    logic [2:0]    sel_n;
    logic          act_n;
    logic          btn_attack_q, tick_cond_q;
    logic          attack_pending, hit_pending;

    logic signed [10:0] delta, pos_sum;

    // Edge-detected so a timing stage that holds hcount==0 for several
    // clocks (pixel clock slower than clk) still yields a single tick.
    logic tick_cond, tick;
    assign tick_cond = (vcount == 10'(TICK_LINE)) && (hcount == 10'd0);
    assign tick      = tick_cond && !tick_cond_q;

    // Events arriving on the tick cycle itself are resolved on that tick.
    logic attack_edge, atk_now, hit_now, go_left, go_right;
    assign attack_edge = btn_attack && !btn_attack_q;
    assign atk_now     = attack_pending || attack_edge;
    assign hit_now     = hit_pending || hit;
    assign go_left     = btn_left && !btn_right;
    assign go_right    = btn_right && !btn_left;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur             <= ST_IDLE;
            sprite_position <= 10'(START_X);
            sprite_select   <= 3'd0;
            attack_active   <= 1'b0;
            timer           <= '0;
            anim_cnt        <= '0;
            anim_frame      <= 1'b0;
            attack_pending  <= 1'b0;
            hit_pending     <= 1'b0;
            btn_attack_q    <= 1'b0;
            tick_cond_q     <= 1'b0;
        end else begin
            btn_attack_q <= btn_attack;
            tick_cond_q  <= tick_cond;
            if (tick) begin
                cur             <= nxt;
                sprite_position <= pos_n;
                sprite_select   <= sel_n;
                attack_active   <= act_n;
                timer           <= timer_n;
                anim_cnt        <= anim_cnt_n;
                anim_frame      <= anim_frame_n;
                attack_pending  <= 1'b0;
                hit_pending     <= 1'b0;
            end else begin
                if (hit)         hit_pending    <= 1'b1;
                if (attack_edge) attack_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt          = cur;
        timer_n      = timer;
        anim_cnt_n   = anim_cnt;
        anim_frame_n = anim_frame;
        delta        = '0;

        if (hit_now && cur != ST_STUN) begin
            nxt     = ST_STUN;
            timer_n = STUN_LOAD;
        end else if (atk_now && (cur == ST_IDLE || cur == ST_WALK)) begin
            nxt     = ST_ATTACK;
            timer_n = ATK_LOAD;
        end else begin
            unique case (cur)
                ST_IDLE, ST_WALK: begin
                    if (go_left || go_right) begin
                        nxt   = ST_WALK;
                        delta = go_left ? -WSTEP : WSTEP;
                        if (cur == ST_IDLE) begin
                            anim_cnt_n   = '0;
                            anim_frame_n = 1'b0;
                        end else if (anim_cnt == ANIM_LAST) begin
                            anim_cnt_n   = '0;
                            anim_frame_n = !anim_frame;
                        end else begin
                            anim_cnt_n = anim_cnt + 1'b1;
                        end
                    end else begin
                        nxt = ST_IDLE;
                    end
                end
                ST_ATTACK: begin
                    if (timer == '0) nxt = ST_IDLE;
                    else timer_n = timer - 1'b1;
                end
                ST_STUN: begin
                    delta = -KBACK;
                    if (timer == '0) nxt = ST_IDLE;
                    else timer_n = timer - 1'b1;
                end
                default: ;
            endcase
        end

        // Signed 11-bit sum so stepping left of 0 goes negative instead of wrapping.
        pos_sum = $signed({1'b0, sprite_position}) + delta;
        if (pos_sum[10])          pos_n = 10'd0;
        else if (pos_sum > MAX_X) pos_n = MAX_X[9:0];
        else                      pos_n = pos_sum[9:0];

        sel_n = 3'd0;
        unique case (nxt)
            ST_IDLE:   sel_n = 3'd0;
            ST_WALK:   sel_n = anim_frame_n ? 3'd2 : 3'd1;
            ST_ATTACK: sel_n = (timer_n >= ATK_HALF) ? 3'd3 : 3'd4;
            ST_STUN:   sel_n = 3'd5;
            default:   sel_n = 3'd0;
        endcase
        act_n = (nxt == ST_ATTACK) && (sel_n == 3'd4);
    end

endmodule

// File: tb/tb_fighter_controller.sv
// Scoreboard bench for fighter_controller: stimulus pushes expected outputs,
// a monitor pops and compares after every reset or tick edge.
module tb_fighter_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hcount = 10'd5;
    logic [9:0] vcount = 10'd0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_attack = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] sprite_position, pos_b;
    logic [2:0] sprite_select, sel_b;
    logic       attack_active, act_b;
    logic [1:0] state, state_b;

    always #5 clk = ~clk;

    fighter_controller dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack), .hit(hit),
        .sprite_position(sprite_position), .sprite_select(sprite_select),
        .attack_active(attack_active), .state(state)
    );

    // Second copy starting at x=1 to exercise the left clamp from an odd position.
    fighter_controller #(.START_X(1)) dut_odd (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack), .hit(hit),
        .sprite_position(pos_b), .sprite_select(sel_b),
        .attack_active(act_b), .state(state_b)
    );

    typedef struct {
        logic [1:0] st;
        logic [9:0] pos;
        logic [2:0] sel;
        logic       act;
        logic       chk_b;
        logic [9:0] pos_b;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic ok;

    task automatic expect_out(input int st, input int pos, input int sel, input int act,
                              input int chk_b, input int pb, input string tag);
        exp_t e;
        e.st = 2'(st); e.pos = 10'(pos); e.sel = 3'(sel); e.act = 1'(act);
        e.chk_b = 1'(chk_b); e.pos_b = 10'(pb); e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_tick();
        vcount = 10'd480; hcount = 10'd0;
        @(negedge clk);
        vcount = 10'd0; hcount = 10'd5;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_attack();
        btn_attack = 1'b1;
        @(negedge clk);
        btn_attack = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
    endtask

    function automatic int walk_sel(input int k);
        return ((((k - 1) / 8) % 2) == 1) ? 2 : 1;
    endfunction

    always @(posedge clk) begin
        if (reset || (vcount == 10'd480 && hcount == 10'd0)) begin
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: st=%0d pos=%0d sel=%0d act=%0d, no expectation queued",
                         state, sprite_position, sprite_select, attack_active);
            end else begin
                mon_e = sb.pop_front();
                ok = (state == mon_e.st) && (sprite_position == mon_e.pos) &&
                     (sprite_select == mon_e.sel) && (attack_active == mon_e.act);
                if (mon_e.chk_b && pos_b != mon_e.pos_b) ok = 1'b0;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got st=%0d pos=%0d sel=%0d act=%0d pos_b=%0d, want st=%0d pos=%0d sel=%0d act=%0d pos_b=%0d(chk=%0d)",
                             mon_e.tag, state, sprite_position, sprite_select, attack_active, pos_b,
                             mon_e.st, mon_e.pos, mon_e.sel, mon_e.act, mon_e.pos_b, mon_e.chk_b);
                end
            end
        end
    end

    initial begin
        int p;
        repeat (3) @(negedge clk);

        expect_out(0, 100, 0, 0, 1, 1, "reset");
        do_reset();

        btn_left = 1'b1;
        expect_out(1, 98, 1, 0, 1, 0, "odd_left_clamp1");
        do_tick();
        expect_out(1, 96, 1, 0, 1, 0, "odd_left_clamp2");
        do_tick();
        btn_left = 1'b0;

        expect_out(0, 100, 0, 0, 1, 1, "reset2");
        do_reset();

        btn_right = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_out(1, 100 + 2 * k, 1, 0, 1, 1 + 2 * k, "walk_right3");
            do_tick();
        end
        btn_right = 1'b0;
        expect_out(0, 106, 0, 0, 1, 7, "release_idle");
        do_tick();

        btn_left = 1'b1; btn_right = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            expect_out(0, 106, 0, 0, 1, 7, "both_held");
            do_tick();
        end
        btn_left = 1'b0; btn_right = 1'b0;

        pulse_attack();
        for (int i = 1; i <= 12; i++) begin
            expect_out(2, 106, (12 - i >= 6) ? 3 : 4, (12 - i >= 6) ? 0 : 1, 0, 0, "attack");
            do_tick();
        end
        btn_right = 1'b1;
        expect_out(0, 106, 0, 0, 0, 0, "attack_exit");
        do_tick();
        expect_out(1, 108, 1, 0, 0, 0, "dir_after_exit");
        do_tick();
        btn_right = 1'b0;
        expect_out(0, 108, 0, 0, 0, 0, "idle_108");
        do_tick();

        btn_right = 1'b1;
        for (int k = 1; k <= 263; k++) begin
            p = 108 + 2 * k;
            if (p > 632) p = 632;
            expect_out(1, p, walk_sel(k), 0, 0, 0, "walk_right_clamp");
            do_tick();
        end
        btn_right = 1'b0;
        expect_out(0, 632, 0, 0, 0, 0, "idle_632");
        do_tick();

        btn_left = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            expect_out(1, 632 - 2 * k, walk_sel(k), 0, 0, 0, "walk_left_anim");
            do_tick();
        end
        btn_left = 1'b0;
        expect_out(0, 598, 0, 0, 0, 0, "idle_598");
        do_tick();

        expect_out(0, 100, 0, 0, 1, 1, "reset3");
        do_reset();
        btn_left = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            expect_out(1, 100 - 2 * k, walk_sel(k), 0, 1, 0, "walk_left_to10");
            do_tick();
        end
        btn_left = 1'b0;
        expect_out(0, 10, 0, 0, 1, 0, "idle_10");
        do_tick();

        pulse_hit();
        pulse_attack();
        expect_out(3, 10, 5, 0, 1, 0, "stun_entry");
        do_tick();
        for (int i = 2; i <= 16; i++) begin
            p = 10 - 4 * (i - 1);
            if (p < 0) p = 0;
            if (i == 5) begin
                pulse_hit();
                pulse_attack();
            end
            expect_out(3, p, 5, 0, 1, 0, "stun");
            do_tick();
        end
        expect_out(0, 0, 0, 0, 1, 0, "stun_exit");
        do_tick();
        expect_out(0, 0, 0, 0, 1, 0, "stun_no_residual");
        do_tick();

        pulse_attack();
        for (int i = 1; i <= 7; i++) begin
            expect_out(2, 0, (12 - i >= 6) ? 3 : 4, (12 - i >= 6) ? 0 : 1, 1, 0, "attack2");
            do_tick();
        end
        expect_out(0, 100, 0, 0, 1, 1, "reset_mid_strike");
        do_reset();

        pulse_attack();
        expect_out(0, 100, 0, 0, 1, 1, "reset_with_tick");
        reset = 1'b1; vcount = 10'd480; hcount = 10'd0;
        @(negedge clk);
        reset = 1'b0; vcount = 10'd0; hcount = 10'd5;
        @(negedge clk);
        expect_out(0, 100, 0, 0, 1, 1, "no_pending_after_reset");
        do_tick();

        btn_right = 1'b1;
        expect_out(1, 102, 1, 0, 1, 3, "first_tick_after_reset");
        do_tick();
        btn_right = 1'b0;
        expect_out(0, 102, 0, 0, 1, 3, "final_idle");
        do_tick();

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
